piso_shift_tx: RTL

//  Parallel-in serial-out transmitter; the sending end of the 8-bit SIPO shift-register link.

---
 rtl/piso_shift_tx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_tx
// Description : Parallel-in serial-out transmitter. A word is accepted over a
//               valid/ready handshake and sent one bit per enabled clock on
//               serial_out. tx_active qualifies the serial stream for the
//               receiving SIPO. Optional parity bit is enabled by defining
//               the macro PISO_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             tx_active,
  output logic             frame_done
);

  localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
`ifdef PISO_PARITY_EN
    S_PARITY = 2'd3,
`endif
    S_DONE   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   w_shreg_nxt;
  logic [WIDTH-1:0]   w_shifted;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_serial;
  logic               w_serial_nxt;
  logic               w_head_nxt;

`ifdef PISO_PARITY_EN
  logic               r_parity;
  logic               w_parity_nxt;
`else
  // PARITY_ODD has no effect without the parity stage.
  logic               w_unused_cfg;
  assign w_unused_cfg = (PARITY_ODD != 0);
`endif

  // Bit order: select the shift direction and which end of the register is the
  // bit currently on the wire. Vacated positions fill with zero.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      logic w_unused_dropped;
      assign w_shifted        = {r_shreg[WIDTH-2:0], 1'b0};
      assign w_head_nxt       = w_shreg_nxt[WIDTH-1];
      assign w_unused_dropped = r_shreg[WIDTH-1];
    end else begin : g_lsb_first
      logic w_unused_dropped;
      assign w_shifted        = {1'b0, r_shreg[WIDTH-1:1]};
      assign w_head_nxt       = w_shreg_nxt[0];
      assign w_unused_dropped = r_shreg[0];
    end
  endgenerate

  // Next-state logic: handshake capture, bit consumption and frame sequencing.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_cnt_nxt    = r_cnt;
`ifdef PISO_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        if (load_valid) begin
          w_state_nxt  = S_SHIFT;
          w_shreg_nxt  = load_data;
          w_cnt_nxt    = '0;
`ifdef PISO_PARITY_EN
          w_parity_nxt = (^load_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      S_SHIFT: begin
        if (shift_en) begin
          w_shreg_nxt = w_shifted;
          if (r_cnt == c_last_cnt) begin
            w_cnt_nxt = '0;
`ifdef PISO_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        if (shift_en) begin
          w_state_nxt = S_DONE;
        end
      end
`endif
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Serial bit for the next cycle, derived from next state so serial_out is a flop.
  always_comb begin
    w_serial_nxt = 1'b0;
    case (w_state_nxt)
      S_SHIFT:  w_serial_nxt = w_head_nxt;
`ifdef PISO_PARITY_EN
      S_PARITY: w_serial_nxt = w_parity_nxt;
`endif
      default:  w_serial_nxt = 1'b0;
    endcase
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_serial <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_cnt    <= w_cnt_nxt;
      r_serial <= w_serial_nxt;
    end
  end

`ifdef PISO_PARITY_EN
  // Parity of the captured word, held for the whole frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_nxt;
    end
  end

  assign tx_active = (r_state == S_SHIFT) || (r_state == S_PARITY);
`else
  assign tx_active = (r_state == S_SHIFT);
`endif

  assign load_ready = (r_state == S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign serial_out = r_serial;

endmodule
`default_nettype wire
